ldl_delay_pipe_v2: RTL and testbench

Multi-channel, valid-qualified delay pipeline with a runtime-programmable depth. It is the second-generation enable-gated DFF delay array and generalises it in three ways: channel count, per-stage valid tracking and flush, and safe depth reconfiguration through a drain state machine. It sits between datapath stages that need matched latency that software can retune without corrupting in-flight samples.

---
 rtl/ldl_delay_pipe_v2_pkg.sv | 16 +
 rtl/ldl_delay_pipe_v2_stage.sv | 52 +++++
 rtl/ldl_delay_pipe_v2.sv | 158 +++++++++++++++
 tb/tb_ldl_delay_pipe_v2.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldl_delay_pipe_v2_pkg.sv
// Shared definitions for the LDL programmable-depth delay blocks: drain FSM
// state encoding and the depth range check used when a new level is requested.
package LDL_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        APPLY = 2'd2
    } ldl_dly_state_t;

    // A requested depth is usable only if it selects an existing physical stage.
    function automatic logic level_ok(input int level, input int max_level);
        return (level >= 1) && (level <= max_level);
    endfunction

endpackage

// File: rtl/ldl_delay_pipe_v2_stage.sv
// One pipeline stage: CHANNELS*WIDTH data register plus its valid bit.
// Data reset on rst/flush exists only when LDL_DELAY_DATA_RST_EN is defined.
module ldl_delay_stage
    import LDL_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    input  logic          i_flush,
    input  logic          i_drop,
    input  logic [DW-1:0] i_d,
    input  logic          i_v,
    output logic [DW-1:0] o_d,
    output logic          o_v
);

    logic [DW-1:0] r_d;
    logic          r_v;

    // Valid clears ignore en: a flush or depth change must never be stalled.
    // NOTE: sequential state uses <= so every stage samples its neighbour's old value.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush || i_drop) begin
            r_v <= 1'b0;
        end else if (i_en) begin
            r_v <= i_v;
        end
    end

`ifdef LDL_DELAY_DATA_RST_EN
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_d <= '0;
        end else if (i_en) begin
            r_d <= i_d;
        end
    end
`else
    // NOTE: data registers are deliberately reset-free; the valid bit alone qualifies them.
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            r_d <= i_d;
        end
    end
`endif

    assign o_d = r_d;
    assign o_v = r_v;

endmodule

// File: rtl/ldl_delay_pipe_v2.sv
// Multi-channel valid-qualified delay pipe with runtime depth and drain-safe
// reconfiguration. Optional data reset: define LDL_DELAY_DATA_RST_EN.
module ldl_delay_pipe_v2
    import LDL_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  int CHANNELS  = 1,
    parameter  int MAX_LEVEL = 8,
    parameter  int DEF_LEVEL = MAX_LEVEL,
    localparam int LW        = $clog2(MAX_LEVEL + 1),
    localparam int DW        = CHANNELS * WIDTH
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    input  logic          i_flush,
    input  logic          i_in_vld,
    output logic          o_in_rdy,
    input  logic [DW-1:0] i_din,
    output logic          o_out_vld,
    output logic [DW-1:0] o_dout,
    input  logic          i_cfg_load,
    input  logic [LW-1:0] i_cfg_level,
    output logic          o_cfg_busy,
    output logic          o_cfg_err,
    output logic [LW-1:0] o_cur_level,
    output logic [LW-1:0] o_occupancy
);

    ldl_dly_state_t r_state;
    ldl_dly_state_t w_state_nxt;

    logic [LW-1:0] r_cur_level;
    logic [LW-1:0] r_pend_level;
    logic [LW-1:0] r_occ;
    logic          r_cfg_err;

    logic          w_accept;
    logic          w_deliver;
    logic          w_req_ok;
    logic          w_req_bad;
    logic          w_apply;
    logic [DW-1:0] w_tap_d;
    logic          w_tap_v;

    // Index 0 is the pipe input; index k+1 is the output of stage k.
    logic [DW-1:0]    w_d [MAX_LEVEL+1];
    logic [MAX_LEVEL:0] w_v;

    assign o_in_rdy  = i_en & ~i_flush & (r_state == RUN);
    assign w_accept  = i_in_vld & o_in_rdy;
    assign w_deliver = i_en & o_out_vld;

    assign w_d[0] = i_din;
    assign w_v[0] = w_accept;

    for (genvar k = 0; k < MAX_LEVEL; k++) begin : g_stage
        ldl_delay_stage #(
            .DW (DW)
        ) u_stage (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_en    (i_en),
            .i_flush (i_flush),
            .i_drop  (w_apply),
            .i_d     (w_d[k]),
            .i_v     (w_v[k]),
            .o_d     (w_d[k+1]),
            .o_v     (w_v[k+1])
        );
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_tap_d = '0;
        w_tap_v = 1'b0;
        for (int k = 0; k < MAX_LEVEL; k++) begin
            if (r_cur_level == LW'(k + 1)) begin
                w_tap_d = w_d[k+1];
                w_tap_v = w_v[k+1];
            end
        end
    end

    assign o_out_vld = w_tap_v & ~i_flush;
    assign o_dout    = w_tap_d;

    // FSM only moves on en cycles, so a stalled pipe also stalls its reconfiguration.
    always_comb begin
        w_state_nxt = r_state;
        w_req_ok    = 1'b0;
        w_req_bad   = 1'b0;
        w_apply     = 1'b0;
        case (r_state)
            RUN: begin
                if (i_en && i_cfg_load) begin
                    if (level_ok(32'(i_cfg_level), MAX_LEVEL)) begin
                        w_req_ok    = 1'b1;
                        w_state_nxt = DRAIN;
                    end else begin
                        w_req_bad = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (i_en && (r_occ == '0)) begin
                    w_state_nxt = APPLY;
                end
            end
            APPLY: begin
                if (i_en) begin
                    w_apply     = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= RUN;
            r_cur_level  <= LW'(DEF_LEVEL);
            r_pend_level <= LW'(DEF_LEVEL);
            r_cfg_err    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cfg_err <= w_req_bad;
            if (w_req_ok) begin
                r_pend_level <= i_cfg_level;
            end
            if (w_apply) begin
                r_cur_level <= r_pend_level;
            end
        end
    end

    // Counts valid samples in the active window; accept and deliver together cancel.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_occ <= '0;
        end else if (i_flush || w_apply) begin
            r_occ <= '0;
        end else if (w_accept && !w_deliver) begin
            r_occ <= r_occ + LW'(1);
        end else if (!w_accept && w_deliver) begin
            r_occ <= r_occ - LW'(1);
        end
    end

    assign o_cfg_busy  = (r_state != RUN);
    assign o_cfg_err   = r_cfg_err;
    assign o_cur_level = r_cur_level;
    assign o_occupancy = r_occ;

endmodule

// File: tb/tb_ldl_delay_pipe_v2.sv
// Scoreboard bench for ldl_delay_pipe_v2: stimulus pushes expected samples with
// their due en-cycle; a negedge monitor pops and compares on every delivery.
module tb_ldl_delay_pipe_v2;

    localparam int DW = 16;
    localparam int LW = 4;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
        int            acc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst, en, flush, in_vld, in_rdy, out_vld;
    logic          cfg_load, cfg_busy, cfg_err;
    logic [DW-1:0] din, dout;
    logic [LW-1:0] cfg_level, cur_level, occupancy;

    int            n_tests  = 0;
    int            n_fail   = 0;
    int            edge_idx = 0;
    int            wall     = 0;
    int            m_level  = 4;
    int            last_lat = 0;
    logic          drv_push = 1'b0;
    logic [DW-1:0] drv_data = '0;
    exp_t          sb[$];

    always #5 clk = ~clk;

    ldl_delay_pipe_v2 #(
        .WIDTH     (8),
        .CHANNELS  (2),
        .MAX_LEVEL (8),
        .DEF_LEVEL (4)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_en        (en),
        .i_flush     (flush),
        .i_in_vld    (in_vld),
        .o_in_rdy    (in_rdy),
        .i_din       (din),
        .o_out_vld   (out_vld),
        .o_dout      (dout),
        .i_cfg_load  (cfg_load),
        .i_cfg_level (cfg_level),
        .o_cfg_busy  (cfg_busy),
        .o_cfg_err   (cfg_err),
        .o_cur_level (cur_level),
        .o_occupancy (occupancy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: negedge view of the upcoming rising edge.
    always @(negedge clk) begin
        exp_t e;
        wall++;
        if (!rst) begin
            if (en) edge_idx++;
            if (en && out_vld) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 32'(out_vld), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("dout", 32'(dout), 32'(e.data));
                    check("due_en_cycle", 32'(edge_idx), 32'(e.due));
                    last_lat = wall - e.acc;
                end
            end
            if (drv_push) begin
                sb.push_back('{data: drv_data, due: edge_idx + m_level, acc: wall});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_vld   = 1'b0;
        drv_push = 1'b0;
        cfg_load = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        in_vld   = 1'b1;
        din      = {~b, b};
        drv_data = {~b, b};
        drv_push = 1'b1;
        #1;
        check("in_rdy_accept", 32'(in_rdy), 32'd1);
        tick();
    endtask

    task automatic wait_drain(input bit toggle);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            if (toggle) en = ~en;
            tick();
            n++;
        end
        check("drain_done", 32'(sb.size()), 32'd0);
        en = 1'b1;
    endtask

    initial begin
        int busy_cyc;
        int zero_cyc;
        logic [7:0] t2 [3];
        t2[0] = 8'h44; t2[1] = 8'h55; t2[2] = 8'h66;

        rst = 1'b1; en = 1'b1; flush = 1'b0; in_vld = 1'b0; din = '0;
        cfg_load = 1'b0; cfg_level = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_out_vld", 32'(out_vld), 32'd0);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_cur_level", 32'(cur_level), 32'd4);
        check("rst_cfg_busy", 32'(cfg_busy), 32'd0);
        check("rst_cfg_err", 32'(cfg_err), 32'd0);
        check("rst_in_rdy", 32'(in_rdy), 32'd1);
        tick();

        // Back-to-back stream at depth 4.
        send(8'h11); send(8'h22); send(8'h33);
        idle();
        #1;
        check("occ_peak", 32'(occupancy), 32'd3);
        wait_drain(0);
        check("lat_depth4", 32'(last_lat), 32'd4);
        check("occ_empty", 32'(occupancy), 32'd0);

        // en toggling 1/0: same order, twice the wall-clock latency.
        for (int i = 0; i < 3; i++) begin
            en = 1'b1;
            send(t2[i]);
            en = 1'b0;
            drv_push = 1'b0;
            #1;
            check("in_rdy_en0", 32'(in_rdy), 32'd0);
            tick();
        end
        idle();
        wait_drain(1);
        check("lat_toggled", 32'(last_lat), 32'd8);

        // Reconfigure 4 -> 2 with three samples in flight.
        send(8'h77); send(8'h88); send(8'h99);
        idle();
        cfg_load = 1'b1; cfg_level = 4'd2;
        #1;
        tick();
        cfg_load = 1'b0; in_vld = 1'b1; din = 16'h55AA;
        #1;
        busy_cyc = 0; zero_cyc = 0;
        for (int i = 0; i < 30 && cfg_busy; i++) begin
            busy_cyc++;
            if (occupancy == '0) zero_cyc++;
            tick();
        end
        check("reconf_busy_cycles", 32'(busy_cyc), 32'd5);
        check("reconf_zero_occ_cycles", 32'(zero_cyc), 32'd2);
        check("reconf_cur_level", 32'(cur_level), 32'd2);
        idle();
        m_level = 2;
        send(8'hAA);
        idle();
        wait_drain(0);
        check("lat_depth2", 32'(last_lat), 32'd2);

        // Out-of-range requests.
        cfg_load = 1'b1; cfg_level = 4'd0;
        #1; tick();
        cfg_load = 1'b0;
        #1;
        check("err_lvl0", 32'(cfg_err), 32'd1);
        check("err_lvl0_busy", 32'(cfg_busy), 32'd0);
        tick();
        check("err_lvl0_clear", 32'(cfg_err), 32'd0);
        cfg_load = 1'b1; cfg_level = 4'd9;
        #1; tick();
        cfg_load = 1'b0;
        #1;
        check("err_lvl9", 32'(cfg_err), 32'd1);
        check("err_lvl9_busy", 32'(cfg_busy), 32'd0);
        tick();
        check("err_level_kept", 32'(cur_level), 32'd2);

        // Same-level request still drains/applies; loads while busy are ignored.
        cfg_load = 1'b1; cfg_level = 4'd2;
        #1; tick();
        cfg_level = 4'd0;
        #1;
        check("same_lvl_drain", 32'(cfg_busy), 32'd1);
        tick();
        cfg_load = 1'b0;
        #1;
        check("busy_load_no_err", 32'(cfg_err), 32'd0);
        check("same_lvl_apply", 32'(cfg_busy), 32'd1);
        tick();
        check("same_lvl_done", 32'(cfg_busy), 32'd0);
        check("same_lvl_level", 32'(cur_level), 32'd2);

        cfg_load = 1'b1; cfg_level = 4'd4;
        #1; tick();
        idle();
        tick(); tick();
        check("restore_level", 32'(cur_level), 32'd4);
        m_level = 4;

        // Flush with two samples in flight and a live input.
        send(8'hC1); send(8'hC2);
        flush = 1'b1; in_vld = 1'b1; din = 16'h1234; drv_push = 1'b0;
        #1;
        check("flush_in_rdy", 32'(in_rdy), 32'd0);
        check("flush_out_vld", 32'(out_vld), 32'd0);
        sb.delete();
        tick();
        flush = 1'b0; idle(); din = '0;
        #1;
        check("flush_occ", 32'(occupancy), 32'd0);
        check("flush_out_vld_after", 32'(out_vld), 32'd0);
`ifdef LDL_DELAY_DATA_RST_EN
        check("flush_dout_zero", 32'(dout), 32'd0);
`endif
        for (int i = 0; i < 10; i++) tick();
        check("flush_occ_settled", 32'(occupancy), 32'd0);

        // Reset in the middle of a drain.
        send(8'hD1); send(8'hD2);
        idle();
        cfg_load = 1'b1; cfg_level = 4'd6;
        #1; tick();
        cfg_load = 1'b0;
        #1;
        check("pre_rst_busy", 32'(cfg_busy), 32'd1);
        rst = 1'b1;
        sb.delete();
        tick();
        rst = 1'b0;
        #1;
        check("rst_drain_busy", 32'(cfg_busy), 32'd0);
        check("rst_drain_level", 32'(cur_level), 32'd4);
        check("rst_drain_occ", 32'(occupancy), 32'd0);
        check("rst_drain_out_vld", 32'(out_vld), 32'd0);
        m_level = 4;
        send(8'hE1);
        idle();
        wait_drain(0);
        check("lat_after_rst", 32'(last_lat), 32'd4);

        tick(); tick();
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
